// File: rtl/mem_store_unit_if.sv
// Data-memory write port used by mem_store_unit: word address, lane data, byte enables,
// write strobe and the memory's ready handshake.
interface mem_store_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_we;
    logic            mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_be,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/mem_store_unit.sv
// RV32 store unit: positions SB/SH/SW data on byte lanes and writes it over a ready handshake.
// Define STORE_MISALIGNED_SPLIT_EN to split word-crossing stores into two bus writes.
module mem_store_unit #(
    parameter int XLEN         = 32,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    output logic             busy,
    output logic             done,
    output logic             misaligned_err,
    output logic             bus_err,
    mem_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);
    localparam logic TIMEOUT_EN = (WAIT_TIMEOUT > 0);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [29:0]     a_r;
    logic [63:0]     d_r;
    logic [7:0]      e_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic            done_r;
    logic            misaligned_err_r;
    logic            bus_err_r;
    logic [31:0]     mem_addr_r;
    logic [31:0]     mem_wdata_r;
    logic [3:0]      mem_be_r;
    logic            mem_we_r;

    logic [3:0]      m_s;
    logic [7:0]      e_s;
    logic [31:0]     masked_s;
    logic [63:0]     d_s;
    logic            accept_s;
    logic            timeout_s;
    logic            misal_nxt_s;
    logic            bus_err_nxt_s;
    logic            unused_s;

    // Size mask from funct3; the reserved encoding yields no lanes.
    always_comb begin
        m_s = 4'b0000;
        case (funct3[1:0])
            2'b00:   m_s = 4'b0001;
            2'b01:   m_s = 4'b0011;
            2'b10:   m_s = 4'b1111;
            default: m_s = 4'b0000;
        endcase
    end

    // Bytes outside the store size are cleared before shifting onto the 8-lane window.
    assign e_s      = {4'b0000, m_s} << addr[1:0];
    assign masked_s = wdata & {{8{m_s[3]}}, {8{m_s[2]}}, {8{m_s[1]}}, {8{m_s[0]}}};
    assign d_s      = {32'd0, masked_s} << {addr[1:0], 3'b000};

    assign accept_s  = mem_we_r && mem.mem_ready;
    assign timeout_s = TIMEOUT_EN && (cnt_r == CNT_LAST);
    assign unused_s  = &{1'b0, funct3[2], d_r[63:32], e_r[7:4], a_r};

    // Next-state and error-flag selection.
    always_comb begin
        state_nxt_s   = state_r;
        misal_nxt_s   = 1'b0;
        bus_err_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (funct3[1:0] == 2'b11) begin
                        state_nxt_s = FIN;
                        misal_nxt_s = 1'b1;
                    end
`ifndef STORE_MISALIGNED_SPLIT_EN
                    else if (e_s[7:4] != 4'b0000) begin
                        state_nxt_s = FIN;
                        misal_nxt_s = 1'b1;
                    end
`endif
                    else begin
                        state_nxt_s = WR0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR0: begin
                if (accept_s) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                    if (e_r[7:4] != 4'b0000) begin
                        state_nxt_s = WR1;
                    end else begin
                        state_nxt_s = FIN;
                    end
`else
                    state_nxt_s = FIN;
`endif
                end else if (timeout_s) begin
                    state_nxt_s   = FIN;
                    bus_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = WR0;
                end
            end
`ifdef STORE_MISALIGNED_SPLIT_EN
            WR1: begin
                if (accept_s) begin
                    state_nxt_s = FIN;
                end else if (timeout_s) begin
                    state_nxt_s   = FIN;
                    bus_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = WR1;
                end
            end
`endif
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, captured request, wait counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            a_r              <= 30'd0;
            d_r              <= 64'd0;
            e_r              <= 8'd0;
            cnt_r            <= '0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            misaligned_err_r <= 1'b0;
            bus_err_r        <= 1'b0;
            mem_addr_r       <= 32'd0;
            mem_wdata_r      <= 32'd0;
            mem_be_r         <= 4'b0000;
            mem_we_r         <= 1'b0;
        end else begin
            state_r <= state_nxt_s;

            if ((state_r == IDLE) && start) begin
                a_r <= addr[31:2];
                d_r <= d_s;
                e_r <= e_s;
            end

            // Counter restarts on every state entry so each write gets its own budget.
            if (state_nxt_s != state_r) begin
                cnt_r <= '0;
            end else if ((state_r == WR0) || (state_r == WR1)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= '0;
            end

            busy_r           <= (state_nxt_s != IDLE);
            done_r           <= (state_nxt_s == FIN);
            misaligned_err_r <= misal_nxt_s;
            bus_err_r        <= bus_err_nxt_s;
            mem_we_r         <= (state_nxt_s == WR0) || (state_nxt_s == WR1);

            case (state_nxt_s)
                WR0: begin
                    if (state_r == IDLE) begin
                        mem_addr_r  <= {addr[31:2], 2'b00};
                        mem_wdata_r <= d_s[31:0];
                        mem_be_r    <= e_s[3:0];
                    end
                end
`ifdef STORE_MISALIGNED_SPLIT_EN
                WR1: begin
                    if (state_r == WR0) begin
                        mem_addr_r  <= {a_r + 30'd1, 2'b00};
                        mem_wdata_r <= d_r[63:32];
                        mem_be_r    <= e_r[7:4];
                    end
                end
`endif
                default: mem_be_r <= 4'b0000;
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign misaligned_err = misaligned_err_r;
    assign bus_err        = bus_err_r;
    assign mem.mem_addr   = mem_addr_r;
    assign mem.mem_wdata  = mem_wdata_r;
    assign mem.mem_be     = mem_be_r;
    assign mem.mem_we     = mem_we_r;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed and random stores compared against a
// byte-address reference model; a second instance with WAIT_TIMEOUT=4 covers bus timeouts.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_to = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, mis, berr;
    logic        busy_t, done_t, mis_t, berr_t;
    int          checks = 0;
    int          errors = 0;

    mem_store_unit_if #(.XLEN(32)) m0 ();
    mem_store_unit_if #(.XLEN(32)) m1 ();

    always #5 clk = ~clk;

    mem_store_unit #(.XLEN(32), .WAIT_TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .misaligned_err(mis), .bus_err(berr), .mem(m0)
    );

    mem_store_unit #(.XLEN(32), .WAIT_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .start(start_to), .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy_t), .done(done_t), .misaligned_err(mis_t), .bus_err(berr_t), .mem(m1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: each store byte i goes to byte address addr+i; bytes are grouped by word.
    function automatic void model(input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                                  output int n, output logic rej,
                                  output logic [1:0][31:0] ea, output logic [1:0][3:0] eb,
                                  output logic [1:0][31:0] ed);
        int sz;
        int w;
        int lane;
        logic [31:0] b;
        n = 0; rej = 1'b0; ea = '0; eb = '0; ed = '0;
        if (f3[1:0] == 2'b11) begin
            rej = 1'b1;
            return;
        end
        sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++) begin
            b = ad + 32'(i);
            w = (b[31:2] == ad[31:2]) ? 0 : 1;
            lane = int'(b[1:0]);
            ea[w] = {b[31:2], 2'b00};
            eb[w][lane] = 1'b1;
            ed[w][8*lane +: 8] = wd[8*i +: 8];
            if (w + 1 > n) n = w + 1;
        end
`ifndef STORE_MISALIGNED_SPLIT_EN
        if (n == 2) begin
            rej = 1'b1;
            n = 0;
        end
`endif
    endfunction

    // One store on the main instance; hold = stall cycles before ready, rnd = random ready plus stray starts.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                             input int hold, input bit rnd);
        logic [1:0][31:0] ea, ed;
        logic [1:0][3:0]  eb;
        int n, cyc, nw, stalls, lat;
        logic rej, rdy, pend;
        logic [31:0] pa, pd;
        logic [3:0] pb;
        bit seen;
        model(f3, ad, wd, n, rej, ea, eb, ed);
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; addr = ad; wdata = wd; m0.mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; addr = $urandom; wdata = $urandom;
        cyc = 1; nw = 0; stalls = 0; lat = 0; seen = 1'b0; pend = 1'b0;
        pa = 32'd0; pd = 32'd0; pb = 4'd0;
        while (!seen && cyc < 40) begin
            if (pend) begin
                chk("hold_we", 32'(m0.mem_we), 32'd1);
                chk("hold_addr", m0.mem_addr, pa);
                chk("hold_data", m0.mem_wdata, pd);
                chk("hold_be", 32'(m0.mem_be), 32'(pb));
            end
            rdy = rnd ? ($urandom_range(0, 2) != 0) : (stalls >= hold);
            m0.mem_ready = rdy;
            if (m0.mem_we) begin
                if (!rdy) stalls++;
                if (rdy) begin
                    if (nw < n) begin
                        chk("wr_addr", m0.mem_addr, ea[nw]);
                        chk("wr_be", 32'(m0.mem_be), 32'(eb[nw]));
                        chk("wr_data", m0.mem_wdata, ed[nw]);
                    end else begin
                        chk("wr_count_over", 32'(nw + 1), 32'(n));
                    end
                    nw++;
                end
            end else begin
                chk("be_idle", 32'(m0.mem_be), 32'd0);
            end
            pend = m0.mem_we && !rdy;
            pa = m0.mem_addr; pd = m0.mem_wdata; pb = m0.mem_be;
            if (done) begin
                seen = 1'b1;
                lat = cyc;
                chk("misaligned_err", 32'(mis), 32'(rej));
                chk("bus_err", 32'(berr), 32'd0);
                chk("we_at_done", 32'(m0.mem_we), 32'd0);
            end else begin
                chk("flags_quiet", 32'({mis, berr}), 32'd0);
            end
            if (rnd) begin
                start = 1'($urandom_range(0, 1));
                funct3 = 3'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("write_count", 32'(nw), 32'(n));
        if (!rnd && hold == 0)
            chk("latency_ok", 32'(rej ? (lat >= 1 && lat <= 2) : (lat == n + 1)), 32'd1);
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_done", 32'(done), 32'd0);
        chk("after_we", 32'(m0.mem_we), 32'd0);
    endtask

    initial begin
        int cyc, wec;
        bit seen;
        logic [31:0] ra;
        m0.mem_ready = 1'b0;
        m1.mem_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({mis, berr}), 32'd0);
        chk("rst_we", 32'(m0.mem_we), 32'd0);
        chk("rst_be", 32'(m0.mem_be), 32'd0);
        chk("rst_addr", m0.mem_addr, 32'd0);
        chk("rst_wdata", m0.mem_wdata, 32'd0);
        chk("rst_to_state", 32'({busy_t, done_t, mis_t, berr_t, m1.mem_we}), 32'd0);
        rst = 1'b0;

        run_store(3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 1'b0);
        run_store(3'b001, 32'h0000_2002, 32'h1234_5678, 3, 1'b0);
        run_store(3'b010, 32'h0000_3001, 32'h1122_3344, 0, 1'b0);
        run_store(3'b011, 32'h0000_0000, 32'h0000_0000, 0, 1'b0);
        run_store(3'b010, 32'hFFFF_FFFE, 32'hCAFE_BABE, 0, 1'b0);
        run_store(3'b101, 32'h0000_6003, 32'h0000_BEEF, 0, 1'b0);
        run_store(3'b010, 32'h0000_7000, 32'h0BAD_F00D, 2, 1'b1);
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            if ($urandom_range(0, 4) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            run_store(3'($urandom_range(0, 7)), ra, $urandom, 0, 1'b1);
        end

        // Reset while a write is stalled in WR0.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000; wdata = 32'h0000_0055; m0.mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_mid_pre_we", 32'(m0.mem_we), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_we", 32'(m0.mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_be", 32'(m0.mem_be), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m0.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_after_quiet", 32'({done, busy, m0.mem_we}), 32'd0);
        end

        // Timeout on the WAIT_TIMEOUT=4 instance with ready held low.
        @(posedge clk); #1;
        start_to = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start_to = 1'b0;
        cyc = 1; wec = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            if (m1.mem_we) begin
                wec++;
                chk("to_addr", m1.mem_addr, 32'h0000_4000);
                chk("to_be", 32'(m1.mem_be), 32'hF);
            end
            if (done_t) begin
                seen = 1'b1;
                chk("to_bus_err", 32'(berr_t), 32'd1);
                chk("to_mis", 32'(mis_t), 32'd0);
                chk("to_we_off", 32'(m1.mem_we), 32'd0);
                chk("to_latency", 32'(cyc), 32'd5);
            end else begin
                chk("to_flags_quiet", 32'(berr_t), 32'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("to_done_seen", 32'(seen), 32'd1);
        chk("to_we_cycles", 32'(wec), 32'd4);
        chk("to_idle_after", 32'({busy_t, berr_t, done_t}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
